// File: rtl/hazard_pkg.sv
// hazard_pkg: FSM state encoding and write-back select codes shared by the
// hazard controller and the forwarding/write-back muxes.
package hazard_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_FAULT    = 2'd2
   } state_e;

   localparam logic [1:0] WDSEL_ALU = 2'b00;
   localparam logic [1:0] WDSEL_MEM = 2'b01;
   localparam logic [1:0] WDSEL_PC4 = 2'b10;
   localparam logic [1:0] WDSEL_IMM = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb cnt_d = (inc && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign count = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipe (load-use,
// taken-branch squash, dmem freeze with timeout fault) plus perf counters.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_W   = 5,
   parameter int WDSEL_W = 2,
   parameter int MEM_TMO = 15,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [REG_W-1:0]   ID_rR1,
   input  logic [REG_W-1:0]   ID_rR2,
   input  logic               ID_re1,
   input  logic               ID_re2,
   input  logic [REG_W-1:0]   EX_wR,
   input  logic               EX_we,
   input  logic [WDSEL_W-1:0] EX_WDSel,
   input  logic               EX_br_taken,
   input  logic               MEM_req,
   input  logic               dmem_ack,
   output logic               PC_we,
   output logic               IF_ID_we,
   output logic               IF_ID_flush,
   output logic               ID_EX_we,
   output logic               ID_EX_flush,
   output logic               EX_MEM_we,
   output logic               MEM_WB_flush,
   output logic               fault,
   output logic [CNT_W-1:0]   cnt_lu,
   output logic [CNT_W-1:0]   cnt_br,
   output logic [CNT_W-1:0]   cnt_mem
);

   state_e     state_q, state_d;
   logic [3:0] wait_q, wait_d;
   logic       lu, mw, flt, halt, frz, br_act, lu_act;

   always_comb begin
      lu     = EX_we && (EX_WDSel == WDSEL_W'(WDSEL_MEM)) && (EX_wR != '0) &&
               ((ID_re1 && (ID_rR1 == EX_wR)) || (ID_re2 && (ID_rR2 == EX_wR)));
      mw     = MEM_req && !dmem_ack;
      flt    = (state_q == ST_FAULT);
      halt   = rst || flt;
      // Priority FAULT > mem freeze > branch squash > load-use stall.
      frz    = !flt && mw;
      br_act = !flt && !mw && EX_br_taken;
      lu_act = !flt && !mw && !EX_br_taken && lu;
   end

   always_comb begin
      PC_we        = !halt && !frz && !lu_act;
      IF_ID_we     = !halt && !frz && !lu_act;
      IF_ID_flush  = halt || br_act;
      ID_EX_we     = !halt && !frz;
      ID_EX_flush  = halt || br_act || lu_act;
      EX_MEM_we    = !halt && !frz;
      MEM_WB_flush = halt || frz;
      fault        = flt;
   end

   // wait_q counts MEM_WAIT cycles; entry from RUN loads 1 since wait_q is 0 there.
   always_comb begin
      state_d = flt ? ST_FAULT :
                !mw ? ST_RUN :
                ((state_q == ST_MEM_WAIT) && (wait_q == 4'(MEM_TMO))) ? ST_FAULT :
                ST_MEM_WAIT;
      wait_d  = (flt || !mw) ? 4'd0 : wait_q + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         wait_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_cnt_lu (
      .clk(clk), .rst(rst), .inc(lu_act), .count(cnt_lu)
   );

   sat_counter #(.CNT_W(CNT_W)) u_cnt_br (
      .clk(clk), .rst(rst), .inc(br_act), .count(cnt_br)
   );

   sat_counter #(.CNT_W(CNT_W)) u_cnt_mem (
      .clk(clk), .rst(rst), .inc(frz), .count(cnt_mem)
   );

endmodule
